// File: rtl/photodiode_phase_meter.sv
// photodiode_phase_meter
// Multi-channel photodiode edge-phase meter. A free-running phase counter defines the
// modulation period; synchronised per-channel edges are stamped with the current phase
// and accumulated over a frame of 2^FBITS periods. At frame end the per-channel average
// phase, hit count and saturation flag are snapshotted and frame_valid pulses once.
module photodiode_phase_meter #(
   parameter int NCH        = 5,
   parameter int CBITS      = 12,
   parameter int FBITS      = 12,
   parameter int OBITS      = 8,
   parameter int SYNC       = 2,
   parameter int GATE_START = 3584
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [1:0]               edge_sel,
   input  logic [NCH-1:0]           pd,
   output logic [CBITS-1:0]         phase,
   output logic                     gate,
   output logic                     frame_valid,
   output logic [NCH*OBITS-1:0]     delays,
   output logic [NCH*(FBITS+1)-1:0] hits,
   output logic [NCH-1:0]           sat
);

   localparam int ABITS = CBITS + FBITS;
   localparam int HBITS = FBITS + 1;
   // One extra bit so a threshold of 2^CBITS (gate never drops) is representable.
   localparam logic [CBITS:0] GATE_TH = (CBITS+1)'(GATE_START);

   logic [NCH-1:0]   sync_reg [SYNC];
   logic [NCH-1:0]   hist_reg;
   logic [NCH-1:0]   rise_reg;
   logic [NCH-1:0]   fall_reg;
   logic [CBITS-1:0] phase_reg, phase_next;
   logic [FBITS-1:0] frame_reg, frame_next;
   logic             gate_reg, gate_next;
   logic             valid_reg;
   logic             frame_end;

   // Synchroniser chain, history flop and registered rise/fall pulses (run regardless of en).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC; k++) sync_reg[k] <= '0;
         hist_reg <= '0;
         rise_reg <= '0;
         fall_reg <= '0;
      end else begin
         sync_reg[0] <= pd;
         for (int k = 1; k < SYNC; k++) sync_reg[k] <= sync_reg[k-1];
         hist_reg <= sync_reg[SYNC-1];
         rise_reg <= sync_reg[SYNC-1] & ~hist_reg;
         fall_reg <= ~sync_reg[SYNC-1] & hist_reg;
      end
   end

   // Phase/frame counters next state, frame-end detect and gate look-ahead.
   always_comb begin
      phase_next = '0;
      frame_next = '0;
      frame_end  = 1'b0;
      gate_next  = 1'b0;
      if (en) begin
         phase_next = phase_reg + CBITS'(1);
         frame_next = (&phase_reg) ? frame_reg + FBITS'(1) : frame_reg;
         frame_end  = (&phase_reg) & (&frame_reg);
         gate_next  = ({1'b0, phase_next} < GATE_TH);
      end
   end

   // Timebase registers; gate is computed from phase_next so it lines up with phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_reg <= '0;
         frame_reg <= '0;
         gate_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         phase_reg <= phase_next;
         frame_reg <= frame_next;
         gate_reg  <= gate_next;
         valid_reg <= frame_end;
      end
   end

   assign phase       = phase_reg;
   assign gate        = gate_reg;
   assign frame_valid = valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic             hit_now;
         logic [ABITS:0]   acc_sum;
         logic [HBITS:0]   hit_sum;
         logic [ABITS-1:0] acc_reg, acc_next;
         logic [HBITS-1:0] hit_reg, hit_next;
         logic             flag_reg, flag_next;
         logic [OBITS-1:0] delay_reg;
         logic [HBITS-1:0] hsnap_reg;
         logic             sat_reg;

         // Edge selection and saturating accumulate for the edge counted this cycle.
         always_comb begin
            hit_now = 1'b0;
            case (edge_sel)
               2'b00:   hit_now = rise_reg[gi];
               2'b01:   hit_now = fall_reg[gi];
               2'b10:   hit_now = rise_reg[gi] | fall_reg[gi];
               default: hit_now = 1'b0;
            endcase
            acc_sum   = {1'b0, acc_reg} + {{(FBITS+1){1'b0}}, phase_reg};
            hit_sum   = {1'b0, hit_reg} + (HBITS+1)'(1);
            acc_next  = acc_reg;
            hit_next  = hit_reg;
            flag_next = flag_reg;
            if (hit_now) begin
               acc_next  = acc_sum[ABITS] ? '1 : acc_sum[ABITS-1:0];
               hit_next  = hit_sum[HBITS] ? '1 : hit_sum[HBITS-1:0];
               flag_next = flag_reg | acc_sum[ABITS] | hit_sum[HBITS];
            end
         end

         // Frame state clears on en low or frame end; snapshot captures the final values.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               acc_reg   <= '0;
               hit_reg   <= '0;
               flag_reg  <= 1'b0;
               delay_reg <= '0;
               hsnap_reg <= '0;
               sat_reg   <= 1'b0;
            end else if (!en) begin
               acc_reg   <= '0;
               hit_reg   <= '0;
               flag_reg  <= 1'b0;
            end else if (frame_end) begin
               acc_reg   <= '0;
               hit_reg   <= '0;
               flag_reg  <= 1'b0;
               delay_reg <= acc_next[ABITS-1 -: OBITS];
               hsnap_reg <= hit_next;
               sat_reg   <= flag_next;
            end else begin
               acc_reg   <= acc_next;
               hit_reg   <= hit_next;
               flag_reg  <= flag_next;
            end
         end

         assign delays[gi*OBITS +: OBITS] = delay_reg;
         assign hits[gi*HBITS +: HBITS]   = hsnap_reg;
         assign sat[gi]                   = sat_reg;
      end
   endgenerate

endmodule

// File: tb/tb_photodiode_phase_meter.sv
// tb_photodiode_phase_meter
// Directed frames on a small configuration (2 channels, 16-cycle period, 4-period frame).
// An edge driven onto pd in cycle c is counted in cycle c+3 with that cycle's phase.
module tb_photodiode_phase_meter;

   localparam int NCH        = 2;
   localparam int CBITS      = 4;
   localparam int FBITS      = 2;
   localparam int OBITS      = 4;
   localparam int SYNC       = 2;
   localparam int GATE_START = 14;

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b1;
   logic             en       = 1'b0;
   logic [1:0]       edge_sel = 2'b11;
   logic [NCH-1:0]   pd       = '0;
   logic [CBITS-1:0] phase;
   logic             gate;
   logic             frame_valid;
   logic [7:0]       delays;
   logic [5:0]       hits;
   logic [1:0]       sat;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Snapshot values the DUT is expected to be holding right now.
   logic [7:0] snap_d = '0;
   logic [5:0] snap_h = '0;
   logic [1:0] snap_s = '0;

   photodiode_phase_meter #(
      .NCH(NCH), .CBITS(CBITS), .FBITS(FBITS), .OBITS(OBITS),
      .SYNC(SYNC), .GATE_START(GATE_START)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .edge_sel(edge_sel), .pd(pd),
      .phase(phase), .gate(gate), .frame_valid(frame_valid),
      .delays(delays), .hits(hits), .sat(sat)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one 64-cycle frame from phase 0 and checks the snapshot in the cycle after it.
   // first: 0 = en held low 4 cycles beforehand, 1 = continues straight from a frame end,
   //        2 = starts in the cycle reset was released.
   task automatic run_frame(input int mode, input int first, input logic [7:0] exp_d,
                            input logic [5:0] exp_h, input logic [1:0] exp_s, input string name);
      int   p;
      logic exp_gate;
      logic exp_fv;
      if (first == 0) begin
         en = 1'b0;
         repeat (4) step();
      end
      en = 1'b1;
      for (int c = 0; c < 64; c++) begin
         p = c % 16;
         case (mode)
            1: begin
               if (p == 2)  pd[0] = 1'b1;
               if (p == 10) pd[0] = 1'b0;
            end
            2: if (p == 0 || p == 8) pd[1] = ~pd[1];
            3: if (c == 60) pd[0] = 1'b1;
            6: if (c % 4 == 0 && c < 60) pd = ~pd;
            default: ;
         endcase
         exp_fv   = (c == 0 && first == 1);
         exp_gate = (c == 0) ? (first == 1) : (p < GATE_START);
         vec_cnt++;
         if (phase !== CBITS'(p) || gate !== exp_gate || frame_valid !== exp_fv) begin
            err_cnt++;
            $display("FAIL %s_timebase cyc %0d: phase=%0d gate=%b fv=%b, required phase=%0d gate=%b fv=%b",
                     name, c, phase, gate, frame_valid, p, exp_gate, exp_fv);
         end
         vec_cnt++;
         if (delays !== snap_d || hits !== snap_h || sat !== snap_s) begin
            err_cnt++;
            $display("FAIL %s_hold cyc %0d: delays=%h hits=%h sat=%b, required delays=%h hits=%h sat=%b",
                     name, c, delays, hits, sat, snap_d, snap_h, snap_s);
         end
         step();
      end
      vec_cnt++;
      if (frame_valid !== 1'b1 || phase !== '0) begin
         err_cnt++;
         $display("FAIL %s_valid: fv=%b phase=%0d, required fv=1 phase=0", name, frame_valid, phase);
      end
      vec_cnt++;
      if (delays !== exp_d) begin
         err_cnt++;
         $display("FAIL %s_delays: got %h, required %h", name, delays, exp_d);
      end
      vec_cnt++;
      if (hits !== exp_h) begin
         err_cnt++;
         $display("FAIL %s_hits: got %h, required %h", name, hits, exp_h);
      end
      vec_cnt++;
      if (sat !== exp_s) begin
         err_cnt++;
         $display("FAIL %s_sat: got %b, required %b", name, sat, exp_s);
      end
      $display("frame %s: delays=%h hits=%h sat=%b", name, delays, hits, sat);
      snap_d = exp_d;
      snap_h = exp_h;
      snap_s = exp_s;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      step();
      step();
      vec_cnt++;
      if (phase !== '0 || gate !== 1'b0 || frame_valid !== 1'b0 ||
          delays !== '0 || hits !== '0 || sat !== '0) begin
         err_cnt++;
         $display("FAIL reset_state: phase=%0d gate=%b fv=%b delays=%h hits=%h sat=%b, required all 0",
                  phase, gate, frame_valid, delays, hits, sat);
      end
      rst_n = 1'b1;
      step();
      step();
      vec_cnt++;
      if (phase !== '0 || gate !== 1'b0 || frame_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL idle_en_low: phase=%0d gate=%b fv=%b, required 0 0 0", phase, gate, frame_valid);
      end
      $display("reset: phase=%0d gate=%b fv=%b", phase, gate, frame_valid);
   endtask

   // Rising edge on ch0 at phase 5 every period: mean 5, 4 hits.
   task automatic test_rise();
      edge_sel = 2'b00;
      run_frame(1, 0, 8'h05, 6'h04, 2'b00, "rise");
   endtask

   // Both edges on ch1 at phases 3 and 11: 8 edges saturate the 3-bit count at 7, sum 56.
   task automatic test_both_sat();
      edge_sel = 2'b10;
      run_frame(2, 0, 8'hE0, 6'h38, 2'b10, "both_sat");
   endtask

   // en low mid-frame: timebase parks at 0, gate low, snapshot held, partial frame discarded.
   task automatic test_en_low();
      edge_sel = 2'b00;
      for (int i = 0; i < 20; i++) begin
         if (i == 2) pd[0] = 1'b1;
         if (i == 6) pd[0] = 1'b0;
         step();
      end
      en = 1'b0;
      for (int j = 0; j < 10; j++) begin
         step();
         vec_cnt++;
         if (phase !== '0 || gate !== 1'b0 || frame_valid !== 1'b0 ||
             delays !== snap_d || hits !== snap_h || sat !== snap_s) begin
            err_cnt++;
            $display("FAIL en_low cyc %0d: phase=%0d gate=%b fv=%b delays=%h hits=%h sat=%b, required 0 0 0 %h %h %b",
                     j, phase, gate, frame_valid, delays, hits, sat, snap_d, snap_h, snap_s);
         end
      end
      $display("en_low: held delays=%h hits=%h sat=%b", delays, hits, sat);
      run_frame(1, 0, 8'h05, 6'h04, 2'b00, "en_restart");
   endtask

   // Asynchronous reset between edges clears every output at once; a fresh frame follows.
   task automatic test_async_reset();
      repeat (20) step();
      #2 rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (phase !== '0 || gate !== 1'b0 || frame_valid !== 1'b0 ||
          delays !== '0 || hits !== '0 || sat !== '0) begin
         err_cnt++;
         $display("FAIL async_reset: phase=%0d gate=%b fv=%b delays=%h hits=%h sat=%b, required all 0",
                  phase, gate, frame_valid, delays, hits, sat);
      end
      $display("async_reset: phase=%0d delays=%h hits=%h", phase, delays, hits);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      snap_d = '0;
      snap_h = '0;
      snap_s = '0;
      run_frame(1, 2, 8'h05, 6'h04, 2'b00, "post_reset");
   endtask

   // Edge counted in the frame-end cycle (phase 15, period 3) lands in that frame's snapshot.
   task automatic test_frame_end_edge();
      edge_sel = 2'b00;
      run_frame(3, 0, 8'h03, 6'h01, 2'b00, "end_edge");
      run_frame(0, 1, 8'h00, 6'h00, 2'b00, "after_end");
   endtask

   // edge_sel=11 ignores all activity but frames keep completing.
   task automatic test_none();
      edge_sel = 2'b11;
      run_frame(6, 0, 8'h00, 6'h00, 2'b00, "none");
      run_frame(6, 1, 8'h00, 6'h00, 2'b00, "none_b2b");
   endtask

   initial begin
      test_reset();
      test_rise();
      test_both_sat();
      test_en_low();
      test_async_reset();
      test_frame_end_edge();
      test_none();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
